// File: rtl/xgmii_port_switch.sv
// xgmii_port_switch: NPORT-way XGMII fan-out (TX) and select (RX) between one
// application stream and NPORT 10GBASE-R paths; mask/port changes only between
// frames, partial frames replaced by idles, frame/drop activity counted.
// Ports: xgmii_clk/sys_rst_n; app_txd/c -> port_txd/c (per tx_mask_act);
// port_rxd/c[rx_sel_act] -> app_rxd/c; link_up, tx_en_mask, rx_sel requests;
// tx_mask_act, rx_sel_act, rx_switch_pend status; tx/rx frame and drop counters.
module xgmii_port_switch #(
  parameter int NPORT = 4,
  parameter int SELW  = 2
) (
  input  logic                 xgmii_clk,
  input  logic                 sys_rst_n,
  input  logic [63:0]          app_txd,
  input  logic [7:0]           app_txc,
  output logic [NPORT*64-1:0]  port_txd,
  output logic [NPORT*8-1:0]   port_txc,
  input  logic [NPORT*64-1:0]  port_rxd,
  input  logic [NPORT*8-1:0]   port_rxc,
  input  logic [NPORT-1:0]     link_up,
  input  logic [NPORT-1:0]     tx_en_mask,
  input  logic [SELW-1:0]      rx_sel,
  output logic [63:0]          app_rxd,
  output logic [7:0]           app_rxc,
  output logic [NPORT-1:0]     tx_mask_act,
  output logic [SELW-1:0]      rx_sel_act,
  output logic                 rx_switch_pend,
  output logic [31:0]          tx_frame_cnt,
  output logic [31:0]          rx_frame_cnt,
  output logic [15:0]          rx_drop_cnt
);

  localparam logic [63:0] IDLE_D = 64'h0707070707070707;
  localparam logic [7:0]  IDLE_C = 8'hFF;

  function automatic logic is_start4(input logic [63:0] d,
                                     input logic [7:0]  c);
    return c[4] && (d[39:32] == 8'hFB);
  endfunction

  function automatic logic is_start(input logic [63:0] d,
                                    input logic [7:0]  c);
    return (c[0] && (d[7:0] == 8'hFB)) || is_start4(d, c);
  endfunction

  function automatic logic is_term(input logic [63:0] d,
                                   input logic [7:0]  c);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 8; i++)
      if (c[i] && (d[8*i +: 8] == 8'hFD)) r = 1'b1;
    return r;
  endfunction

  // Terminate plus lane-4 start in one word keeps the stream in a frame.
  function automatic logic inf_next(input logic        cur,
                                    input logic [63:0] d,
                                    input logic [7:0]  c);
    logic s, t;
    s = is_start(d, c);
    t = is_term(d, c);
    if (s && t)  return is_start4(d, c);
    else if (t)  return 1'b0;
    else if (s)  return 1'b1;
    else         return cur;
  endfunction

  // ---------------- TX ----------------
  logic tx_inf;
  logic tx_start;
  logic tx_bound;

  assign tx_start = is_start(app_txd, app_txc);
  assign tx_bound = !tx_inf && !tx_start;

  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_inf       <= 1'b0;
      tx_mask_act  <= '0;
      tx_frame_cnt <= '0;
      port_txd     <= {NPORT{IDLE_D}};
      port_txc     <= {NPORT{IDLE_C}};
    end else begin
      tx_inf <= inf_next(tx_inf, app_txd, app_txc);
      if (tx_bound)
        tx_mask_act <= tx_en_mask & link_up;
      if (tx_start)
        tx_frame_cnt <= tx_frame_cnt + 32'd1;
      for (int p = 0; p < NPORT; p++) begin
        port_txd[64*p +: 64] <= tx_mask_act[p] ? app_txd : IDLE_D;
        port_txc[8*p +: 8]   <= tx_mask_act[p] ? app_txc : IDLE_C;
      end
    end
  end

  // ---------------- RX ----------------
  logic [NPORT-1:0] rx_inf;
  logic [NPORT-1:0] rx_inf_nxt;
  logic [63:0]      cur_d;
  logic [7:0]       cur_c;
  logic             cur_inf;
  logic             cur_link;
  logic             new_inf;
  logic             new_link;
  logic             sel_ok;
  logic             cur_start;
  logic             cur_term;
  logic             idle_word;
  logic             do_switch;
  logic             deliver;
  logic             discard;
  logic             discard_n;
  logic             drop_inc;

  always_comb begin
    rx_inf_nxt = rx_inf;
    cur_d      = IDLE_D;
    cur_c      = IDLE_C;
    cur_inf    = 1'b0;
    cur_link   = 1'b0;
    new_inf    = 1'b0;
    new_link   = 1'b0;
    sel_ok     = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      rx_inf_nxt[p] = inf_next(rx_inf[p], port_rxd[64*p +: 64],
                               port_rxc[8*p +: 8]);
      if (rx_sel_act == SELW'(p)) begin
        cur_d    = port_rxd[64*p +: 64];
        cur_c    = port_rxc[8*p +: 8];
        cur_inf  = rx_inf[p];
        cur_link = link_up[p];
      end
      if (rx_sel == SELW'(p)) begin
        new_inf  = rx_inf_nxt[p];
        new_link = link_up[p];
        sel_ok   = 1'b1;
      end
    end
  end

  assign cur_start      = is_start(cur_d, cur_c);
  assign cur_term       = is_term(cur_d, cur_c);
  assign idle_word      = (cur_c == 8'hFF) && !cur_start;
  assign rx_switch_pend = (rx_sel != rx_sel_act);
  // A dead link on the current port is never waited on.
  assign do_switch      = rx_switch_pend && sel_ok &&
                          ((!cur_inf && !cur_start) || !cur_link);
  assign deliver        = !discard && cur_link;

  always_comb begin
    discard_n = discard;
    drop_inc  = 1'b0;
    if (do_switch) begin
      discard_n = new_inf || !new_link;
      drop_inc  = new_inf;
    end else if (!discard && !cur_link && (cur_inf || cur_start)) begin
      discard_n = 1'b1;
      drop_inc  = 1'b1;
    end else if (discard && (cur_term || (cur_link && idle_word))) begin
      discard_n = 1'b0;
    end
  end

  // discard starts set so a frame already running at reset release is
  // hidden until its port shows an idle or terminate word.
  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_inf       <= '0;
      rx_sel_act   <= '0;
      discard      <= 1'b1;
      rx_frame_cnt <= '0;
      rx_drop_cnt  <= '0;
      app_rxd      <= IDLE_D;
      app_rxc      <= IDLE_C;
    end else begin
      rx_inf  <= rx_inf_nxt;
      discard <= discard_n;
      if (do_switch)
        rx_sel_act <= rx_sel;
      if (drop_inc && (rx_drop_cnt != 16'hFFFF))
        rx_drop_cnt <= rx_drop_cnt + 16'd1;
      if (deliver && cur_term)
        rx_frame_cnt <= rx_frame_cnt + 32'd1;
      app_rxd <= deliver ? cur_d : IDLE_D;
      app_rxc <= deliver ? cur_c : IDLE_C;
    end
  end

endmodule

// File: tb/tb_xgmii_port_switch.sv
// tb_xgmii_port_switch: directed bench for xgmii_port_switch (NPORT=4,
// 3-bit rx_sel so an out-of-range port can be requested).
module tb_xgmii_port_switch;

  localparam logic [63:0] IDLE_D = 64'h0707070707070707;
  localparam logic [71:0] IDLE_W = {8'hFF, IDLE_D};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [63:0]   app_txd;
  logic [7:0]    app_txc;
  logic [255:0]  port_txd;
  logic [31:0]   port_txc;
  logic [255:0]  port_rxd;
  logic [31:0]   port_rxc;
  logic [3:0]    link_up;
  logic [3:0]    tx_en_mask;
  logic [2:0]    rx_sel;
  logic [63:0]   app_rxd;
  logic [7:0]    app_rxc;
  logic [3:0]    tx_mask_act;
  logic [2:0]    rx_sel_act;
  logic          rx_switch_pend;
  logic [31:0]   tx_frame_cnt;
  logic [31:0]   rx_frame_cnt;
  logic [15:0]   rx_drop_cnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  xgmii_port_switch #(.NPORT(4), .SELW(3)) dut (
    .xgmii_clk      (clk),
    .sys_rst_n      (rst_n),
    .app_txd        (app_txd),
    .app_txc        (app_txc),
    .port_txd       (port_txd),
    .port_txc       (port_txc),
    .port_rxd       (port_rxd),
    .port_rxc       (port_rxc),
    .link_up        (link_up),
    .tx_en_mask     (tx_en_mask),
    .rx_sel         (rx_sel),
    .app_rxd        (app_rxd),
    .app_rxc        (app_rxc),
    .tx_mask_act    (tx_mask_act),
    .rx_sel_act     (rx_sel_act),
    .rx_switch_pend (rx_switch_pend),
    .tx_frame_cnt   (tx_frame_cnt),
    .rx_frame_cnt   (rx_frame_cnt),
    .rx_drop_cnt    (rx_drop_cnt)
  );

  // Frame word k of an n-word frame: start, data..., terminate in lane 3.
  function automatic logic [71:0] fword(input int k, input int n,
                                        input logic [7:0] tag);
    if (k == 0)
      return {8'h01, 64'hD5555555555555FB};
    else if (k == n - 1)
      return {8'hF8, 32'h07070707, 8'hFD, tag, 8'(k), 8'hAA};
    else
      return {8'h00, tag, 8'(k), 48'h0123456789AB};
  endfunction

  function automatic logic [287:0] exp_tx(input logic [3:0] m,
                                          input logic [71:0] w);
    logic [255:0] d;
    logic [31:0]  c;
    for (int p = 0; p < 4; p++) begin
      d[64*p +: 64] = m[p] ? w[63:0]  : IDLE_D;
      c[8*p +: 8]   = m[p] ? w[71:64] : 8'hFF;
    end
    return {c, d};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_tx(input logic [71:0] w);
    app_txd = w[63:0];
    app_txc = w[71:64];
  endtask

  task automatic set_rx(input int p, input logic [71:0] w);
    port_rxd[64*p +: 64] = w[63:0];
    port_rxc[8*p +: 8]   = w[71:64];
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({app_rxc, app_rxd} !== IDLE_W)
      $display("FAIL reset_app_rx got %h exp %h", {app_rxc, app_rxd}, IDLE_W);
    else passed++;
    checks++;
    if ({port_txc, port_txd} !== exp_tx(4'h0, IDLE_W))
      $display("FAIL reset_port_tx got %h", {port_txc, port_txd});
    else passed++;
    checks++;
    if ({tx_frame_cnt, rx_frame_cnt, rx_drop_cnt} !== 80'h0)
      $display("FAIL reset_counters got %h/%h/%h exp 0", tx_frame_cnt,
               rx_frame_cnt, rx_drop_cnt);
    else passed++;
    checks++;
    if (tx_mask_act !== 4'h0 || rx_sel_act !== 3'd0)
      $display("FAIL reset_act got mask %b sel %0d exp 0/0",
               tx_mask_act, rx_sel_act);
    else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_tx_fanout;
    logic [71:0] w;
    tx_en_mask = 4'b1111;
    tick();
    tick();
    checks++;
    if (tx_mask_act !== 4'b1111)
      $display("FAIL fanout_mask got %b exp 1111", tx_mask_act);
    else passed++;
    for (int k = 0; k < 10; k++) begin
      w = fword(k, 10, 8'h11);
      set_tx(w);
      tick();
      checks++;
      if ({port_txc, port_txd} !== exp_tx(4'b1111, w))
        $display("FAIL fanout_word%0d got %h exp %h", k,
                 {port_txc, port_txd}, exp_tx(4'b1111, w));
      else passed++;
    end
    set_tx(IDLE_W);
    tick();
    checks++;
    if (tx_frame_cnt !== 32'd1)
      $display("FAIL fanout_cnt got %0d exp 1", tx_frame_cnt);
    else passed++;
  endtask

  task automatic test_tx_mask_change;
    logic [71:0] w;
    tx_en_mask = 4'b0001;
    tick();
    tick();
    checks++;
    if (tx_mask_act !== 4'b0001)
      $display("FAIL mask_pre got %b exp 0001", tx_mask_act);
    else passed++;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) tx_en_mask = 4'b0110;
      w = fword(k, 6, 8'h22);
      set_tx(w);
      tick();
      checks++;
      if ({port_txc, port_txd} !== exp_tx(4'b0001, w))
        $display("FAIL mask_old_word%0d got %h exp %h", k,
                 {port_txc, port_txd}, exp_tx(4'b0001, w));
      else passed++;
    end
    checks++;
    if (tx_mask_act !== 4'b0001)
      $display("FAIL mask_held got %b exp 0001", tx_mask_act);
    else passed++;
    set_tx(IDLE_W);
    tick();
    checks++;
    if (tx_mask_act !== 4'b0110)
      $display("FAIL mask_new got %b exp 0110", tx_mask_act);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      w = fword(k, 4, 8'h23);
      set_tx(w);
      tick();
      checks++;
      if ({port_txc, port_txd} !== exp_tx(4'b0110, w))
        $display("FAIL mask_new_word%0d got %h exp %h", k,
                 {port_txc, port_txd}, exp_tx(4'b0110, w));
      else passed++;
    end
    set_tx(IDLE_W);
    tick();
    checks++;
    if (tx_frame_cnt !== 32'd3)
      $display("FAIL mask_cnt got %0d exp 3", tx_frame_cnt);
    else passed++;
  endtask

  task automatic test_rx_switch_after_frame;
    logic [71:0] w;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) rx_sel = 3'd2;
      w = fword(k, 6, 8'h30);
      set_rx(0, w);
      tick();
      checks++;
      if ({app_rxc, app_rxd} !== w)
        $display("FAIL sw0_word%0d got %h exp %h", k, {app_rxc, app_rxd}, w);
      else passed++;
    end
    checks++;
    if (rx_switch_pend !== 1'b1 || rx_sel_act !== 3'd0)
      $display("FAIL sw_pending got pend %b sel %0d exp 1/0",
               rx_switch_pend, rx_sel_act);
    else passed++;
    set_rx(0, IDLE_W);
    tick();
    checks++;
    if (rx_sel_act !== 3'd2 || rx_switch_pend !== 1'b0)
      $display("FAIL sw_done got sel %0d pend %b exp 2/0",
               rx_sel_act, rx_switch_pend);
    else passed++;
    for (int k = 0; k < 5; k++) begin
      w = fword(k, 5, 8'h32);
      set_rx(2, w);
      tick();
      checks++;
      if ({app_rxc, app_rxd} !== w)
        $display("FAIL sw2_word%0d got %h exp %h", k, {app_rxc, app_rxd}, w);
      else passed++;
    end
    set_rx(2, IDLE_W);
    tick();
    checks++;
    if (rx_frame_cnt !== 32'd2 || rx_drop_cnt !== 16'd0)
      $display("FAIL sw_cnt got %0d/%0d exp 2/0", rx_frame_cnt, rx_drop_cnt);
    else passed++;
  endtask

  task automatic test_rx_discard_midframe;
    logic [71:0] w;
    rx_sel = 3'd0;
    tick();
    checks++;
    if (rx_sel_act !== 3'd0)
      $display("FAIL dis_back got %0d exp 0", rx_sel_act);
    else passed++;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) rx_sel = 3'd1;
      set_rx(1, fword(k, 6, 8'h41));
      tick();
      checks++;
      if ({app_rxc, app_rxd} !== IDLE_W)
        $display("FAIL dis_word%0d got %h exp %h", k,
                 {app_rxc, app_rxd}, IDLE_W);
      else passed++;
    end
    checks++;
    if (rx_drop_cnt !== 16'd1 || rx_frame_cnt !== 32'd2 || rx_sel_act !== 3'd1)
      $display("FAIL dis_cnt got drop %0d frm %0d sel %0d exp 1/2/1",
               rx_drop_cnt, rx_frame_cnt, rx_sel_act);
    else passed++;
    set_rx(1, IDLE_W);
    tick();
    for (int k = 0; k < 4; k++) begin
      w = fword(k, 4, 8'h42);
      set_rx(1, w);
      tick();
      checks++;
      if ({app_rxc, app_rxd} !== w)
        $display("FAIL dis_next_word%0d got %h exp %h", k,
                 {app_rxc, app_rxd}, w);
      else passed++;
    end
    set_rx(1, IDLE_W);
    tick();
    checks++;
    if (rx_frame_cnt !== 32'd3)
      $display("FAIL dis_next_cnt got %0d exp 3", rx_frame_cnt);
    else passed++;
  endtask

  task automatic test_rx_link_drop;
    logic [71:0] w;
    rx_sel = 3'd0;
    tick();
    for (int k = 0; k < 7; k++) begin
      if (k == 3) link_up = 4'b1110;
      if (k == 5) link_up = 4'b1111;
      w = fword(k, 7, 8'h50);
      set_rx(0, w);
      tick();
      checks++;
      if (k < 3) begin
        if ({app_rxc, app_rxd} !== w)
          $display("FAIL link_word%0d got %h exp %h", k,
                   {app_rxc, app_rxd}, w);
        else passed++;
      end else begin
        if ({app_rxc, app_rxd} !== IDLE_W)
          $display("FAIL link_word%0d got %h exp %h", k,
                   {app_rxc, app_rxd}, IDLE_W);
        else passed++;
      end
    end
    checks++;
    if (rx_drop_cnt !== 16'd2 || rx_frame_cnt !== 32'd3)
      $display("FAIL link_cnt got drop %0d frm %0d exp 2/3",
               rx_drop_cnt, rx_frame_cnt);
    else passed++;
    set_rx(0, IDLE_W);
    tick();
    for (int k = 0; k < 3; k++) begin
      w = fword(k, 3, 8'h51);
      set_rx(0, w);
      tick();
      checks++;
      if ({app_rxc, app_rxd} !== w)
        $display("FAIL link_next_word%0d got %h exp %h", k,
                 {app_rxc, app_rxd}, w);
      else passed++;
    end
    set_rx(0, IDLE_W);
    tick();
    checks++;
    if (rx_frame_cnt !== 32'd4)
      $display("FAIL link_next_cnt got %0d exp 4", rx_frame_cnt);
    else passed++;
    rx_sel = 3'd5;
    tick();
    tick();
    checks++;
    if (rx_switch_pend !== 1'b1 || rx_sel_act !== 3'd0)
      $display("FAIL bad_sel got pend %b sel %0d exp 1/0",
               rx_switch_pend, rx_sel_act);
    else passed++;
    rx_sel = 3'd0;
    tick();
    checks++;
    if (rx_switch_pend !== 1'b0)
      $display("FAIL bad_sel_clear got pend %b exp 0", rx_switch_pend);
    else passed++;
  endtask

  task automatic test_reset_midframe;
    logic [71:0] w;
    for (int k = 0; k < 3; k++) begin
      set_rx(0, fword(k, 6, 8'h60));
      set_tx(fword(k, 6, 8'h61));
      tick();
    end
    checks++;
    if ({port_txc, port_txd} !== exp_tx(4'b0110, fword(2, 6, 8'h61)))
      $display("FAIL rst_pre_tx got %h", {port_txc, port_txd});
    else passed++;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({app_rxc, app_rxd} !== IDLE_W ||
        {port_txc, port_txd} !== exp_tx(4'h0, IDLE_W))
      $display("FAIL rst_async got rx %h tx %h", {app_rxc, app_rxd},
               {port_txc, port_txd});
    else passed++;
    checks++;
    if ({tx_frame_cnt, rx_frame_cnt, rx_drop_cnt} !== 80'h0)
      $display("FAIL rst_counters got %h/%h/%h exp 0", tx_frame_cnt,
               rx_frame_cnt, rx_drop_cnt);
    else passed++;
    set_tx(IDLE_W);
    tick();
    rst_n = 1'b1;
    for (int k = 3; k < 6; k++) begin
      set_rx(0, fword(k, 6, 8'h60));
      tick();
      checks++;
      if ({app_rxc, app_rxd} !== IDLE_W)
        $display("FAIL rst_partial_word%0d got %h exp %h", k,
                 {app_rxc, app_rxd}, IDLE_W);
      else passed++;
    end
    set_rx(0, IDLE_W);
    tick();
    for (int k = 0; k < 4; k++) begin
      w = fword(k, 4, 8'h62);
      set_rx(0, w);
      set_tx(w);
      tick();
      checks++;
      if ({app_rxc, app_rxd} !== w ||
          {port_txc, port_txd} !== exp_tx(4'b0110, w))
        $display("FAIL rst_post_word%0d got rx %h tx %h exp %h", k,
                 {app_rxc, app_rxd}, {port_txc, port_txd}, w);
      else passed++;
    end
    set_rx(0, IDLE_W);
    set_tx(IDLE_W);
    tick();
    checks++;
    if (rx_frame_cnt !== 32'd1 || tx_frame_cnt !== 32'd1 ||
        rx_drop_cnt !== 16'd0)
      $display("FAIL rst_post_cnt got rx %0d tx %0d drop %0d exp 1/1/0",
               rx_frame_cnt, tx_frame_cnt, rx_drop_cnt);
    else passed++;
  endtask

  initial begin
    rst_n      = 1'b1;
    app_txd    = IDLE_D;
    app_txc    = 8'hFF;
    port_rxd   = {4{IDLE_D}};
    port_rxc   = 32'hFFFFFFFF;
    link_up    = 4'b1111;
    tx_en_mask = 4'b0000;
    rx_sel     = 3'd0;
    test_reset();
    test_tx_fanout();
    test_tx_mask_change();
    test_rx_switch_after_frame();
    test_rx_discard_midframe();
    test_rx_link_drop();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
